miriscv_decode_buf: RTL and testbench

Two-entry decode-stage buffer sitting between instruction fetch and execute. It accepts fetched instructions over a valid/ready handshake and computes each instruction's immediate and opcode field once, at acceptance. It holds up to two decoded entries so that fetch keeps streaming while execute back-pressures. It supports a single-cycle pipeline flush on redirect.

---
 rtl/miriscv_opcodes_pkg.sv | 50 +++++
 rtl/miriscv_imm.sv | 45 ++++
 rtl/miriscv_decode_buf.sv | 121 ++++++++++++
 tb/tb_miriscv_decode_buf.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_opcodes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_opcodes_pkg
// Purpose  : Shared RV32 major-opcode constants, decode-buffer state encoding
//            and the decoded entry record carried by miriscv_decode_buf.
// Revision : 1.0 - initial release
// ============================================================================
package miriscv_opcodes_pkg;

  localparam int XLEN_C = 32;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] S_OPCODE_LOAD     = 5'b00000;
  localparam logic [4:0] S_OPCODE_MISC_MEM = 5'b00011;
  localparam logic [4:0] S_OPCODE_OPIMM    = 5'b00100;
  localparam logic [4:0] S_OPCODE_AUIPC    = 5'b00101;
  localparam logic [4:0] S_OPCODE_STORE    = 5'b01000;
  localparam logic [4:0] S_OPCODE_OP       = 5'b01100;
  localparam logic [4:0] S_OPCODE_LUI      = 5'b01101;
  localparam logic [4:0] S_OPCODE_BRANCH   = 5'b11000;
  localparam logic [4:0] S_OPCODE_JALR     = 5'b11001;
  localparam logic [4:0] S_OPCODE_JAL      = 5'b11011;
  localparam logic [4:0] S_OPCODE_SYSTEM   = 5'b11100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } dec_buf_state_t;

  typedef struct packed {
    logic [XLEN_C-1:0] instr;
    logic [XLEN_C-1:0] pc;
    logic [XLEN_C-1:0] imm;
    logic [4:0]        opcode;
    logic              illegal;
  } dec_entry_t;

  // True for every major opcode the core implements.
  function automatic logic is_known_opcode(input logic [4:0] op);
    case (op)
      S_OPCODE_LUI, S_OPCODE_AUIPC, S_OPCODE_JAL, S_OPCODE_JALR,
      S_OPCODE_BRANCH, S_OPCODE_LOAD, S_OPCODE_STORE, S_OPCODE_OPIMM,
      S_OPCODE_OP, S_OPCODE_MISC_MEM, S_OPCODE_SYSTEM: is_known_opcode = 1'b1;
      default:                                          is_known_opcode = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_imm.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_imm
// Purpose  : Combinational RV32 immediate generator. Selects the I/S/B/U/J
//            format from the major opcode and sign-extends to 32 bits;
//            opcodes without an immediate produce zero.
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_imm
  import miriscv_opcodes_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  logic [4:0] opcode;
  logic       unused_lo;

  assign opcode    = instr_i[6:2];
  // The compressed-marker bits carry no immediate information.
  assign unused_lo = ^instr_i[1:0];

  // Format select and sign extension from instr[31].
  always_comb begin
    imm_o = '0;
    case (opcode)
      S_OPCODE_OPIMM, S_OPCODE_LOAD, S_OPCODE_JALR:
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      S_OPCODE_STORE:
        imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      S_OPCODE_BRANCH:
        imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      S_OPCODE_LUI, S_OPCODE_AUIPC:
        imm_o = {instr_i[31:12], 12'h000};
      S_OPCODE_JAL:
        imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/miriscv_decode_buf.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_decode_buf
// Purpose  : Two-entry decode buffer between fetch and execute. Decodes the
//            immediate/opcode once at acceptance, holds a head and a skid
//            entry, and supports a single-cycle flush.
//            Optional feature macro: MIRISCV_DECODE_ILLEGAL_EN enables
//            illegal-encoding detection on d_illegal_o.
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_decode_buf
  import miriscv_opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            f_valid_i,
  output logic            f_ready_o,
  input  logic [XLEN-1:0] f_instr_i,
  input  logic [XLEN-1:0] f_pc_i,
  output logic            d_valid_o,
  input  logic            d_ready_i,
  output logic [XLEN-1:0] d_instr_o,
  output logic [XLEN-1:0] d_pc_o,
  output logic [XLEN-1:0] d_imm_o,
  output logic [4:0]      d_opcode_o,
  output logic            d_illegal_o
);

  dec_buf_state_t state_q, state_d;
  dec_entry_t     head_q, head_d;
  dec_entry_t     skid_q, skid_d;
  dec_entry_t     new_entry;
  logic [31:0]    imm_raw;
  logic           new_illegal;
  logic           push;
  logic           pop;

  miriscv_imm u_imm (
    .instr_i (f_instr_i),
    .imm_o   (imm_raw)
  );

`ifdef MIRISCV_DECODE_ILLEGAL_EN
  assign new_illegal = (f_instr_i[1:0] != 2'b11) || !is_known_opcode(f_instr_i[6:2]);
`else
  assign new_illegal = 1'b0;
`endif

  // Entry as it will be stored; an illegal encoding carries no immediate.
  assign new_entry.instr   = f_instr_i;
  assign new_entry.pc      = f_pc_i;
  assign new_entry.imm     = new_illegal ? '0 : imm_raw;
  assign new_entry.opcode  = f_instr_i[6:2];
  assign new_entry.illegal = new_illegal;

  // Handshakes depend only on registered state, so no d_ready_i -> f_ready_o path.
  assign f_ready_o = (state_q != FULL);
  assign d_valid_o = (state_q != EMPTY);
  assign push      = f_valid_i & f_ready_o & ~flush_i;
  assign pop       = d_valid_o & d_ready_i & ~flush_i;

  assign d_instr_o   = head_q.instr;
  assign d_pc_o      = head_q.pc;
  assign d_imm_o     = head_q.imm;
  assign d_opcode_o  = head_q.opcode;
  assign d_illegal_o = head_q.illegal;

  // Next-state and data-path selection; flush only empties, data is kept.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = new_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            skid_d  = new_entry;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and entry registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_decode_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_miriscv_decode_buf
// Purpose  : Self-checking bench for miriscv_decode_buf using a queue-based
//            reference model and directed plus random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_miriscv_decode_buf;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        f_valid_i = 1'b0;
  logic        f_ready_o;
  logic [31:0] f_instr_i = '0;
  logic [31:0] f_pc_i = '0;
  logic        d_valid_o;
  logic        d_ready_i = 1'b0;
  logic [31:0] d_instr_o;
  logic [31:0] d_pc_o;
  logic [31:0] d_imm_o;
  logic [4:0]  d_opcode_o;
  logic        d_illegal_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ref_entry_t;

  ref_entry_t model_q[$];

  miriscv_decode_buf #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .f_valid_i   (f_valid_i),
    .f_ready_o   (f_ready_o),
    .f_instr_i   (f_instr_i),
    .f_pc_i      (f_pc_i),
    .d_valid_o   (d_valid_o),
    .d_ready_i   (d_ready_i),
    .d_instr_o   (d_instr_o),
    .d_pc_o      (d_pc_o),
    .d_imm_o     (d_imm_o),
    .d_opcode_o  (d_opcode_o),
    .d_illegal_o (d_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: expected illegal flag from the encoding rules.
  function automatic logic ref_illegal(input logic [31:0] w);
`ifdef MIRISCV_DECODE_ILLEGAL_EN
    int op;
    op = int'(w[6:2]);
    if (w[1:0] != 2'b11) return 1'b1;
    return !(op == 13 || op == 5 || op == 27 || op == 25 || op == 24 || op == 0 ||
             op == 8 || op == 4 || op == 12 || op == 3 || op == 28);
`else
    return 1'b0 & w[0];
`endif
  endfunction

  // Reference immediate computed arithmetically from the field layout.
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int op;
    int neg;
    int v;
    op  = int'(w[6:2]);
    neg = w[31] ? 1 : 0;
    v   = 0;
    if (ref_illegal(w)) return 32'h0;
    case (op)
      4, 0, 25: v = -neg * 2048 + int'(w[30:20]);
      8:        v = -neg * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]);
      24:       v = -neg * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      13, 5:    return w & 32'hFFFF_F000;
      27:       v = -neg * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      default:  v = 0;
    endcase
    return 32'(v);
  endfunction

  // One clock: update model from the inputs held across the edge, then settle.
  task automatic tick();
    logic m_push, m_pop;
    ref_entry_t e;
    m_push = f_valid_i && (model_q.size() < 2) && !flush_i;
    m_pop  = (model_q.size() > 0) && d_ready_i && !flush_i;
    e.instr = f_instr_i;
    e.pc    = f_pc_i;
    @(posedge clk_i);
    if (flush_i) model_q.delete();
    else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic dr, input logic fl);
    f_valid_i = fv;
    f_instr_i = ins;
    f_pc_i    = pc;
    d_ready_i = dr;
    flush_i   = fl;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (d_valid_o !== 1'b0 || f_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: d_valid=%b f_ready=%b required 0/1", d_valid_o, f_ready_o);
    end
    checks++;
    if ({d_instr_o, d_pc_o, d_imm_o, d_opcode_o, d_illegal_o} !== '0) begin
      errors++;
      $display("FAIL reset_payload: instr=%h pc=%h imm=%h op=%b ill=%b required all 0",
               d_instr_o, d_pc_o, d_imm_o, d_opcode_o, d_illegal_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    model_q.delete();
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (d_valid_o !== 1'b1 || d_imm_o !== 32'h5 || d_opcode_o !== 5'b00100 || d_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL addi: valid=%b imm=%h op=%b pc=%h required 1/00000005/00100/00000100",
               d_valid_o, d_imm_o, d_opcode_o, d_pc_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++;
    if (d_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL addi_pop: valid=%b required 0", d_valid_o);
    end
  endtask

  task automatic test_full_order();
    drive(1'b1, 32'h12345137, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hFE000EE3, 32'h204, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hCAFE0013, 32'h208, 1'b0, 1'b0);
    checks++;
    if (f_ready_o !== 1'b0 || d_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL full_state: f_ready=%b d_valid=%b required 0/1", f_ready_o, d_valid_o);
    end
    tick();
    checks++;
    if (d_imm_o !== 32'h12345000 || d_instr_o !== 32'h12345137) begin
      errors++;
      $display("FAIL full_stall: imm=%h instr=%h required 12345000/12345137", d_imm_o, d_instr_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++;
    if (d_imm_o !== 32'hFFFFFFFC || d_pc_o !== 32'h204 || d_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL full_second: imm=%h pc=%h valid=%b required fffffffc/00000204/1",
               d_imm_o, d_pc_o, d_valid_o);
    end
    tick();
    checks++;
    if (d_valid_o !== 1'b0 || f_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_drain: valid=%b f_ready=%b required 0/1", d_valid_o, f_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h00500093, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hFF9FF06F, 32'h304, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (d_valid_o !== 1'b1 || f_ready_o !== 1'b1 || d_imm_o !== 32'hFFFFFFF8 || d_pc_o !== 32'h304) begin
      errors++;
      $display("FAIL push_pop: valid=%b f_ready=%b imm=%h pc=%h required 1/1/fffffff8/00000304",
               d_valid_o, f_ready_o, d_imm_o, d_pc_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++;
    if (d_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_drain: valid=%b required 0", d_valid_o);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00100113, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00200193, 32'h404, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hDEADBEEF, 32'h408, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (d_valid_o !== 1'b0 || f_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush: valid=%b f_ready=%b required 0/1", d_valid_o, f_ready_o);
    end
    drive(1'b1, 32'h00300213, 32'h500, 1'b0, 1'b0);
    tick();
    checks++;
    if (d_instr_o !== 32'h00300213 || d_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: instr=%h valid=%b required 00300213/1", d_instr_o, d_valid_o);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h00000000, 32'h600, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
`ifdef MIRISCV_DECODE_ILLEGAL_EN
    if (d_illegal_o !== 1'b1 || d_imm_o !== 32'h0) begin
      errors++;
      $display("FAIL illegal_zero: ill=%b imm=%h required 1/00000000", d_illegal_o, d_imm_o);
    end
`else
    if (d_illegal_o !== 1'b0 || d_imm_o !== 32'h0) begin
      errors++;
      $display("FAIL illegal_zero: ill=%b imm=%h required 0/00000000", d_illegal_o, d_imm_o);
    end
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] w;
    int pick;
    int opsel[12] = '{13, 5, 27, 25, 24, 0, 8, 4, 12, 3, 28, 10};
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      pick = int'($urandom_range(0, 11));
      w[6:2] = 5'(opsel[pick]);
      if ($urandom_range(0, 9) != 0) w[1:0] = 2'b11;
      drive($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (d_valid_o !== (model_q.size() > 0) || f_ready_o !== (model_q.size() < 2)) begin
        errors++;
        $display("FAIL rand_hs[%0d]: valid=%b f_ready=%b model_size=%0d", i, d_valid_o,
                 f_ready_o, model_q.size());
      end
      if (model_q.size() > 0) begin
        checks++;
        if (d_instr_o !== model_q[0].instr || d_pc_o !== model_q[0].pc ||
            d_imm_o !== ref_imm(model_q[0].instr) || d_opcode_o !== model_q[0].instr[6:2] ||
            d_illegal_o !== ref_illegal(model_q[0].instr)) begin
          errors++;
          $display("FAIL rand_head[%0d]: instr=%h pc=%h imm=%h ill=%b required %h/%h/%h/%b", i,
                   d_instr_o, d_pc_o, d_imm_o, d_illegal_o, model_q[0].instr, model_q[0].pc,
                   ref_imm(model_q[0].instr), ref_illegal(model_q[0].instr));
        end
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h00700393, 32'h700, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00800413, 32'h704, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (d_valid_o !== 1'b0 || f_ready_o !== 1'b1 || d_instr_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b f_ready=%b instr=%h required 0/1/00000000",
               d_valid_o, f_ready_o, d_instr_o);
    end
    model_q.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    drive(1'b1, 32'h00900493, 32'h800, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (d_valid_o !== 1'b1 || d_instr_o !== 32'h00900493 || d_pc_o !== 32'h800) begin
      errors++;
      $display("FAIL reset_first_push: valid=%b instr=%h pc=%h required 1/00900493/00000800",
               d_valid_o, d_instr_o, d_pc_o);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_full_order();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
